// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Arbitrates two register-file write requesters: A for ALU writeback and B for
// load writeback. The arbiter grants one write per cycle. When both requesters
// are valid, the grant alternates between them (round-robin).
// Writes reach the register file one cycle after acceptance. A write to x0 is
// accepted but never reaches the register file.
// Optional build macro RF_CLEAR_EN: when it is defined, every reset is followed
// by a 32-cycle sequence that writes CLEAR_VALUE to every register. Requests
// wait until that sequence has finished.
module regfile_write_arbiter #(
    parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        a_valid_i,
    input  logic [4:0]  a_rd_i,
    input  logic [31:0] a_data_i,
    output logic        a_ready_o,
    input  logic        b_valid_i,
    input  logic [4:0]  b_rd_i,
    input  logic [31:0] b_data_i,
    output logic        b_ready_o,
    output logic [4:0]  rd_o,
    output logic [31:0] datard_o,
    output logic        wren_o,
    output logic        busy_o
);

    logic        in_run;        // arbiter may grant this cycle
    logic        clear_active;  // clear write issued at the coming edge
    logic [4:0]  clear_idx;     // register index being cleared

`ifdef RF_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  clr_cnt_reg, clr_cnt_next;

    // State and clear-counter registers; every reset restarts the clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= 5'd0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // Next-state logic: walk indices 0..31, then leave CLEAR after index 31.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        if (state_reg == ST_CLEAR) begin
            clr_cnt_next = clr_cnt_reg + 5'd1;
            if (clr_cnt_reg == 5'd31) begin
                state_next = ST_RUN;
            end
        end
    end

    assign clear_active = (state_reg == ST_CLEAR) && rst_ni;
    assign clear_idx    = clr_cnt_reg;
    assign busy_o       = (state_reg == ST_CLEAR);
    // The rst_ni term keeps both readies low while reset is asserted.
    assign in_run       = (state_reg == ST_RUN) && rst_ni;
`else
    assign clear_active = 1'b0;
    assign clear_idx    = 5'd0;
    assign busy_o       = 1'b0;
    // Without a clear sequence the arbiter runs as soon as reset releases.
    // The rst_ni term keeps both readies low while reset is asserted.
    assign in_run       = rst_ni;
`endif

    logic        last_b_reg;    // 1 = requester B won the most recent transfer
    logic        grant_a, grant_b;
    logic        xfer;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;
    logic        wren_reg;
    logic [4:0]  rd_reg;
    logic [31:0] data_reg;

    // Grant logic: a lone requester always wins.
    // On a tie, grant the requester that did not win the last transfer.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (in_run) begin
            if (a_valid_i && b_valid_i) begin
                grant_a = last_b_reg;
                grant_b = !last_b_reg;
            end else begin
                grant_a = a_valid_i;
                grant_b = b_valid_i;
            end
        end
    end

    assign a_ready_o = grant_a;
    assign b_ready_o = grant_b;
    assign xfer      = grant_a || grant_b;
    assign sel_rd    = grant_a ? a_rd_i   : b_rd_i;
    assign sel_data  = grant_a ? a_data_i : b_data_i;

    // Registered write port and round-robin pointer.
    // rd/data change only when a real write is issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wren_reg   <= 1'b0;
            rd_reg     <= 5'd0;
            data_reg   <= 32'd0;
            last_b_reg <= 1'b1;
        end else begin
            wren_reg <= 1'b0;
            if (clear_active) begin
                wren_reg <= 1'b1;
                rd_reg   <= clear_idx;
                data_reg <= CLEAR_VALUE;
            end else if (xfer) begin
                last_b_reg <= grant_b;
                if (sel_rd != 5'd0) begin
                    wren_reg <= 1'b1;
                    rd_reg   <= sel_rd;
                    data_reg <= sel_data;
                end
            end
        end
    end

    assign wren_o   = wren_reg;
    assign rd_o     = rd_reg;
    assign datard_o = data_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter.
// Runs a reset check, the post-reset sequence, a reset mid-operation, a vector
// table, and randomized traffic compared against a transaction-level model.
module tb_regfile_write_arbiter;

    localparam logic [31:0] CV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wren, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.CLEAR_VALUE(CV)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .a_valid_i(a_valid), .a_rd_i(a_rd), .a_data_i(a_data), .a_ready_o(a_ready),
        .b_valid_i(b_valid), .b_rd_i(b_rd), .b_data_i(b_data), .b_ready_o(b_ready),
        .rd_o(rd), .datard_o(data), .wren_o(wren), .busy_o(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

`ifdef RF_CLEAR_EN
    // Follows n clear cycles, sampling after each edge.
    // On the last cycle (k==32) the block is in RUN, so a_ready mirrors a_valid.
    task automatic clear_seq(input int n);
        logic exp_rdy;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            exp_rdy = (k == 32) && a_valid;
            chk("clr_wren", wren, 1'b1);
            chk("clr_rd", rd, 5'(k - 1));
            chk("clr_data", data, CV);
            chk("clr_busy", busy, (k < 32));
            chk("clr_a_ready", a_ready, exp_rdy);
        end
    endtask
`endif

    typedef struct packed {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bdata;
        logic        ea;
        logic        eb;
        logic        ew;
        logic [4:0]  erd;
        logic [31:0] edata;
    } vec_t;

    vec_t tbl [9];

    // Transaction-level reference state
    logic        m_last_b;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        pa_v, pb_v, ga, gb, ew;
    logic [4:0]  pa_rd, pb_rd, w_rd;
    logic [31:0] pa_data, pb_data, w_data;

    initial begin
        // Vectors start from a freshly reset pointer, so A wins the first tie.
        tbl[0] = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b1, 5'd1, 32'h11};
        tbl[1] = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b1, 5'd2, 32'h22};
        tbl[2] = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b1, 5'd1, 32'h11};
        tbl[3] = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b1, 5'd2, 32'h22};
        tbl[4] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
        tbl[5] = '{1'b0, 5'd6, 32'h66, 1'b0, 5'd8, 32'h88, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
        tbl[6] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF};
        tbl[7] = '{1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77};
        tbl[8] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99};

        // Reset with both requesters valid: readies and outputs must stay low.
        rst_n = 1'b0;
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'd7;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'd8;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wren", wren, 1'b0);
        chk("rst_rd", rd, 5'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
`ifdef RF_CLEAR_EN
        chk("rst_busy", busy, 1'b1);
`else
        chk("rst_busy", busy, 1'b0);
`endif
        b_valid = 1'b0;
        rst_n = 1'b1;
        #1;
`ifdef RF_CLEAR_EN
        chk("rel_busy", busy, 1'b1);
        chk("rel_a_ready", a_ready, 1'b0);
        // A stays valid throughout the clear; it is accepted in the first RUN cycle.
        clear_seq(32);
`else
        chk("rel_busy", busy, 1'b0);
        chk("rel_a_ready", a_ready, 1'b1);
`endif
        @(posedge clk); #1;
        chk("first_wren", wren, 1'b1);
        chk("first_rd", rd, 5'd3);
        chk("first_data", data, 32'd7);
        chk("first_busy", busy, 1'b0);
        a_valid = 1'b0;

`ifdef RF_CLEAR_EN
        // Restart a clear and interrupt it at index 10.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            chk("pre_abort_rd", rd, 5'(k - 1));
        end
`endif
        // Reset in mid-operation: everything drops immediately.
        a_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("abort_wren", wren, 1'b0);
        chk("abort_rd", rd, 5'd0);
        chk("abort_data", data, 32'd0);
        chk("abort_a_ready", a_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        a_valid = 1'b0;
        rst_n = 1'b1;
        #1;
`ifdef RF_CLEAR_EN
        clear_seq(32);
`endif

        // Vector table
        for (int i = 0; i < 9; i++) begin
            a_valid = tbl[i].av; a_rd = tbl[i].ard; a_data = tbl[i].adata;
            b_valid = tbl[i].bv; b_rd = tbl[i].brd; b_data = tbl[i].bdata;
            #1;
            chk($sformatf("vec%0d_a_ready", i), a_ready, tbl[i].ea);
            chk($sformatf("vec%0d_b_ready", i), b_ready, tbl[i].eb);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_wren", i), wren, tbl[i].ew);
            chk($sformatf("vec%0d_rd", i), rd, tbl[i].erd);
            chk($sformatf("vec%0d_data", i), data, tbl[i].edata);
            chk($sformatf("vec%0d_busy", i), busy, 1'b0);
        end

        // Randomized traffic. B won the last table transfer; the last real
        // write went to x9 with data 0x99.
        m_last_b = 1'b1; m_rd = 5'd9; m_data = 32'h99;
        pa_v = 1'b0; pb_v = 1'b0;
        pa_rd = 5'd0; pb_rd = 5'd0; pa_data = 32'd0; pb_data = 32'd0;
        for (int c = 0; c < 400; c++) begin
            if (!pa_v && $urandom_range(0, 9) < 6) begin
                pa_v = 1'b1;
                pa_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                pa_data = $urandom;
            end
            if (!pb_v && $urandom_range(0, 9) < 6) begin
                pb_v = 1'b1;
                pb_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                pb_data = $urandom;
            end
            a_valid = pa_v; a_rd = pa_rd; a_data = pa_data;
            b_valid = pb_v; b_rd = pb_rd; b_data = pb_data;
            #1;
            ga = 1'b0; gb = 1'b0;
            if (pa_v && pb_v) begin
                if (m_last_b) ga = 1'b1; else gb = 1'b1;
            end else begin
                ga = pa_v;
                gb = pb_v;
            end
            chk("rnd_a_ready", a_ready, ga);
            chk("rnd_b_ready", b_ready, gb);
            ew = 1'b0;
            if (ga || gb) begin
                w_rd   = ga ? pa_rd : pb_rd;
                w_data = ga ? pa_data : pb_data;
                m_last_b = gb;
                if (w_rd != 5'd0) begin
                    ew = 1'b1;
                    m_rd = w_rd;
                    m_data = w_data;
                end
                if (ga) pa_v = 1'b0;
                if (gb) pb_v = 1'b0;
            end
            @(posedge clk); #1;
            chk("rnd_wren", wren, ew);
            chk("rnd_rd", rd, m_rd);
            chk("rnd_data", data, m_data);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
